// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  // funct3 encodings of the M-extension operations
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // Special operand/result values
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StLoadChk,
    StIter,
    StFix,
    StDone
  } state_e;

  // Magnitude of a value that is optionally interpreted as two's complement
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/addsub_33.sv
// Combinational 33-bit adder/subtractor shared by multiply accumulate and trial subtract.
module addsub_33 (
  input  logic [32:0] a_i,
  input  logic [32:0] b_i,
  input  logic        sub_i,
  output logic [32:0] sum_o
);

  // Subtraction is a + ~b + 1; carry out of bit 32 is intentionally dropped
  always_comb begin
    sum_o = a_i + (sub_i ? ~b_i : b_i) + {32'd0, sub_i};
  end

endmodule

// File: rtl/seq_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one 33-bit add/sub per cycle, 32 iterations plus load/fix-up cycles.
module seq_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [31:0] LastIter = 32'(ITER - 1);

  state_e             state_q, state_d;
  logic [2:0]         op_q;
  logic [XLEN-1:0]    rs1_q, rs2_q;
  logic [XLEN-1:0]    a_q;       // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]  acc_q;     // {hi, lo}: product or {remainder, dividend/quotient}
  logic [31:0]        cnt_q;
  logic               neg_q;
  logic [XLEN-1:0]    result_q;

  logic            is_div, div_zero, div_ovf, special;
  logic            neg1, neg2, sign_d;
  logic [31:0]     mag1, mag2, special_res, fix_res;
  logic [32:0]     add_a, add_b, add_sum;
  logic            add_sub;
  logic [63:0]     iter_acc, prod_fix;
  logic [31:0]     quo_fix, rem_fix;

  // Operand classification and special-case detection in LOAD_CHK
  always_comb begin
    is_div   = op_q[2];
    div_zero = is_div && (rs2_q == '0);
    div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
               (rs1_q == INT_MIN) && (rs2_q == ALL_ONES);
    special  = div_zero || div_ovf;

    neg1 = ((op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM))
           && rs1_q[31];
    neg2 = ((op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM)) && rs2_q[31];
    mag1 = magnitude(rs1_q, neg1);
    mag2 = magnitude(rs2_q, neg2);

    // Remainder takes the dividend's sign; everything else the product of signs
    sign_d = (op_q == OP_REM) ? neg1 : (neg1 ^ neg2);

    special_res = '0;
    if (div_zero) begin
      special_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? ALL_ONES : rs1_q;
    end else if (op_q == OP_DIV) begin
      special_res = INT_MIN;
    end
  end

  // Shared adder operand steering: accumulate for multiply, trial subtract for divide
  always_comb begin
    if (is_div) begin
      add_a   = acc_q[63:31];           // remainder shifted left, dividend MSB shifted in
      add_b   = {1'b0, a_q};
      add_sub = 1'b1;
    end else begin
      add_a   = {1'b0, acc_q[63:32]};
      add_b   = acc_q[0] ? {1'b0, a_q} : 33'd0;
      add_sub = 1'b0;
    end
  end

  addsub_33 u_addsub (
    .a_i   (add_a),
    .b_i   (add_b),
    .sub_i (add_sub),
    .sum_o (add_sum)
  );

  // Next accumulator for one iteration, and sign fix-up / output select for FIX
  always_comb begin
    if (is_div) begin
      // Negative trial difference (bit 32 set) restores the shifted remainder
      iter_acc = {(add_sum[32] ? acc_q[62:31] : add_sum[31:0]), acc_q[30:0], ~add_sum[32]};
    end else begin
      // Carry of the accumulate becomes the new top bit as the pair shifts right
      iter_acc = {add_sum, acc_q[31:1]};
    end

    prod_fix = neg_q ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    fix_res = '0;
    unique case (op_q)
      OP_MUL:                       fix_res = prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[63:32];
      OP_DIV, OP_DIVU:              fix_res = quo_fix;
      OP_REM, OP_REMU:              fix_res = rem_fix;
      default:                      fix_res = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StLoadChk;
      StLoadChk: state_d = special ? StDone : StIter;
      StIter:    if (cnt_q == LastIter) state_d = StFix;
      StFix:     state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = (state_q == StLoadChk) || (state_q == StIter) || (state_q == StFix);
    done   = (state_q == StDone);
    result = result_q;
  end

  // Datapath registers: capture, load magnitudes, iterate, fix up
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q  <= funct3;
            rs1_q <= rs1;
            rs2_q <= rs2;
          end
        end
        StLoadChk: begin
          if (special) begin
            result_q <= special_res;
          end else begin
            neg_q <= sign_d;
            cnt_q <= '0;
            if (is_div) begin
              a_q   <= mag2;
              acc_q <= {32'd0, mag1};
            end else begin
              a_q   <= mag1;
              acc_q <= {32'd0, mag2};
            end
          end
        end
        StIter: begin
          acc_q <= iter_acc;
          cnt_q <= cnt_q + 32'd1;
        end
        StFix: begin
          result_q <= fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Directed and randomized checks of seq_muldiv_unit against an arithmetic reference.
module tb_seq_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  seq_muldiv_unit #(
    .XLEN (32),
    .ITER (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Count cycles (sampled #1 after each edge) until done, with a bound
  task automatic wait_done(input int lat0, output int lat, output logic busy_ok);
    lat = lat0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Issue one op; returns in the following IDLE cycle so the next call is back-to-back
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic busy_ok,
                        output logic busy_at_done);
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    wait_done(1, lat, busy_ok);
    res = result;
    busy_at_done = busy;
    if (done === 1'b1) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (f)
      OP_MUL:    begin p = ua * ub; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res, a, b;
    int          lat;
    logic        bok, bdn;
    int          dones;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Multiply family
    run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, res, lat, bok, bdn);
    check("mul_7_m3", res, 32'hFFFF_FFEB);
    check("mul_latency", 32'(lat), 32'd35);
    check("mul_busy_throughout", 32'(bok), 32'd1);
    check("mul_busy_at_done", 32'(bdn), 32'd0);
    run_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, res, lat, bok, bdn);
    check("mulh_min_min", res, 32'h4000_0000);
    check("b2b_latency", 32'(lat), 32'd35);
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bok, bdn);
    check("mulhu_ones", res, 32'hFFFF_FFFE);
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, res, lat, bok, bdn);
    check("mulhsu_m1_2", res, 32'hFFFF_FFFF);

    // Divide family
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, res, lat, bok, bdn);
    check("div_m7_2", res, 32'hFFFF_FFFD);
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, res, lat, bok, bdn);
    check("rem_m7_2", res, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'd100, 32'd7, res, lat, bok, bdn);
    check("divu_100_7", res, 32'd14);
    run_op(OP_REMU, 32'd100, 32'd7, res, lat, bok, bdn);
    check("remu_100_7", res, 32'd2);

    // Special cases
    run_op(OP_DIVU, 32'd5, 32'd0, res, lat, bok, bdn);
    check("divu_by_zero", res, 32'hFFFF_FFFF);
    check("divzero_latency", 32'(lat), 32'd2);
    run_op(OP_REM, 32'd5, 32'd0, res, lat, bok, bdn);
    check("rem_by_zero", res, 32'd5);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bok, bdn);
    check("div_overflow", res, 32'h8000_0000);
    check("ovf_latency", 32'(lat), 32'd2);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bok, bdn);
    check("rem_overflow", res, 32'd0);

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1; funct3 = OP_MUL; rs1 = 32'd3; rs2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; funct3 = OP_DIV; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(6, lat, bok);
    check("ignore_busy_start_result", result, 32'd15);
    check("ignore_busy_start_latency", 32'(lat), 32'd35);
    @(posedge clk); #1;

    // Reset mid-operation aborts without a done pulse
    @(negedge clk);
    start = 1'b1; funct3 = OP_MUL; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midop_rst_busy", 32'(busy), 32'd0);
    check("midop_rst_done", 32'(done), 32'd0);
    check("midop_rst_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("midop_rst_no_done", 32'(dones), 32'd0);
    check("midop_rst_result_held", result, 32'd0);

    // Randomized back-to-back ops with corner operands
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 200; i++) begin
        a = pick();
        b = pick();
        run_op(3'(f), a, b, res, lat, bok, bdn);
        check($sformatf("rand f=%0d a=%h b=%h", f, a, b), res, ref_op(3'(f), a, b));
        if (lat >= 100) check("rand_timeout", 32'(lat), 32'd35);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
